// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the external SRAM access arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ
  } state_t;

  typedef enum logic {
    G_WR,
    G_RD
  } grant_e;

  localparam int unsigned DEFAULT_ACC_CYC = 2;

endpackage

// File: rtl/sram_access_arbiter.sv
// Owns the single external SRAM and time-shares it between the recorder (write)
// and DSP (read) ports using fixed-length, fully registered access windows.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ACC_CYC = DEFAULT_ACC_CYC,
  parameter bit          WR_PRIO = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq_out,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq_in,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_ce_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  if (ACC_CYC < 2) begin : gen_acc_cyc_check
    $error("sram_access_arbiter: ACC_CYC must be >= 2");
  end

  localparam int unsigned CntW = $clog2(ACC_CYC);
  localparam logic [CntW-1:0] CntLoad = CntW'(ACC_CYC - 1);

  state_t              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  grant_e              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dq_out_q, dq_out_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic                busy_q, busy_d;
  logic                wr_ack_q, wr_ack_d;
  logic                rd_ack_q, rd_ack_d;
  logic                en_n_q;
  logic                wr_elig, rd_elig;
  logic                grant_wr, grant_rd;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    dq_out_d     = dq_out_q;
    rd_data_d    = rd_data_q;
    we_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    dq_oe_d      = 1'b0;
    busy_d       = 1'b0;
    wr_ack_d     = 1'b0;
    rd_ack_d     = 1'b0;
    // A port is ineligible during its own ack cycle, so the other port gets a turn.
    wr_elig      = i_wr_req & ~wr_ack_q;
    rd_elig      = i_rd_req & ~rd_ack_q;
    grant_wr     = 1'b0;
    grant_rd     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        grant_wr = wr_elig & (~rd_elig | (last_grant_q == G_RD));
        grant_rd = rd_elig & ~grant_wr;
        if (grant_wr) begin
          state_d      = S_WRITE;
          cnt_d        = CntLoad;
          last_grant_d = G_WR;
          addr_d       = i_wr_addr;
          dq_out_d     = i_wr_data;
          we_n_d       = 1'b0;
          dq_oe_d      = 1'b1;
          busy_d       = 1'b1;
        end else if (grant_rd) begin
          state_d      = S_READ;
          cnt_d        = CntLoad;
          last_grant_d = G_RD;
          addr_d       = i_rd_addr;
          oe_n_d       = 1'b0;
          busy_d       = 1'b1;
        end
      end
      S_WRITE: begin
        if (cnt_q == '0) begin
          state_d  = S_IDLE;
          wr_ack_d = 1'b1;
        end else begin
          cnt_d   = cnt_q - CntW'(1);
          we_n_d  = 1'b0;
          dq_oe_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_READ: begin
        if (cnt_q == '0) begin
          state_d   = S_IDLE;
          rd_ack_d  = 1'b1;
          rd_data_d = i_sram_dq_in;
        end else begin
          cnt_d  = cnt_q - CntW'(1);
          oe_n_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= WR_PRIO ? G_RD : G_WR;
      addr_q       <= '0;
      dq_out_q     <= '0;
      rd_data_q    <= '0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      dq_oe_q      <= 1'b0;
      busy_q       <= 1'b0;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      en_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      dq_out_q     <= dq_out_d;
      rd_data_q    <= rd_data_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      dq_oe_q      <= dq_oe_d;
      busy_q       <= busy_d;
      wr_ack_q     <= wr_ack_d;
      rd_ack_q     <= rd_ack_d;
      en_n_q       <= 1'b0;
    end
  end

  assign o_wr_ack      = wr_ack_q;
  assign o_rd_ack      = rd_ack_q;
  assign o_rd_data     = rd_data_q;
  assign o_busy        = busy_q;
  assign o_sram_addr   = addr_q;
  assign o_sram_dq_out = dq_out_q;
  assign o_sram_dq_oe  = dq_oe_q;
  assign o_sram_we_n   = we_n_q;
  assign o_sram_oe_n   = oe_n_q;
  assign o_sram_ce_n   = en_n_q;
  assign o_sram_lb_n   = en_n_q;
  assign o_sram_ub_n   = en_n_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model and a behavioural SRAM on DQ.
module tb_sram_access_arbiter;

  localparam int ACC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [19:0] wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] sram_dq_in = 16'hDEAD;
  logic        wr_ack, rd_ack, busy, dq_oe, we_n, oe_n, ce_n, lb_n, ub_n;
  logic [15:0] rd_data, dq_out;
  logic [19:0] sram_addr;

  always #5 clk = ~clk;

  sram_access_arbiter #(
    .ADDR_W (20),
    .DATA_W (16),
    .ACC_CYC(ACC),
    .WR_PRIO(1'b1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_wr_req     (wr_req),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .o_wr_ack     (wr_ack),
    .i_rd_req     (rd_req),
    .i_rd_addr    (rd_addr),
    .o_rd_ack     (rd_ack),
    .o_rd_data    (rd_data),
    .o_busy       (busy),
    .o_sram_addr  (sram_addr),
    .o_sram_dq_out(dq_out),
    .o_sram_dq_oe (dq_oe),
    .i_sram_dq_in (sram_dq_in),
    .o_sram_we_n  (we_n),
    .o_sram_oe_n  (oe_n),
    .o_sram_ce_n  (ce_n),
    .o_sram_lb_n  (lb_n),
    .o_sram_ub_n  (ub_n)
  );

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural SRAM seen by the DUT, and the bench's own view of what memory should hold.
  logic [15:0] sram_mem [logic [19:0]];
  logic [15:0] ref_mem  [logic [19:0]];

  function automatic logic [15:0] init_word(input logic [19:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  function logic [15:0] sram_rd(input logic [19:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : init_word(a);
  endfunction

  function logic [15:0] ref_rd(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Transaction-level reference: a grant opens a window of ACC cycles, ack follows it.
  int          win_left = 0;
  bit          win_wr = 1'b0;
  bit          ack_w = 1'b0, ack_r = 1'b0;
  bit          last_wr = 1'b0;
  bit          in_rst = 1'b1;
  logic [19:0] e_addr = '0;
  logic [15:0] e_dq = '0, e_rd = '0;

  task automatic model_edge();
    bit nw, nr, ew, er, pick;
    if (!rst_n) begin
      win_left = 0;
      ack_w = 1'b0;
      ack_r = 1'b0;
      last_wr = 1'b0;
      e_addr = '0;
      e_dq = '0;
      e_rd = '0;
      in_rst = 1'b1;
    end else begin
      in_rst = 1'b0;
      nw = 1'b0;
      nr = 1'b0;
      if (win_left > 0) begin
        win_left--;
        if (win_left == 0) begin
          if (win_wr) begin
            nw = 1'b1;
            ref_mem[e_addr] = e_dq;
          end else begin
            nr = 1'b1;
            e_rd = ref_rd(e_addr);
          end
        end
      end else begin
        ew = wr_req && !ack_w;
        er = rd_req && !ack_r;
        if (ew || er) begin
          pick = (ew && er) ? !last_wr : ew;
          win_left = ACC;
          win_wr = pick;
          last_wr = pick;
          if (pick) begin
            e_addr = wr_addr;
            e_dq = wr_data;
          end else begin
            e_addr = rd_addr;
          end
        end
      end
      ack_w = nw;
      ack_r = nr;
    end
  endtask

  bit busy_prev = 1'b0;
  bit dut_grants[$];

  // One clock: model advances on the edge, DUT is compared on the following falling edge.
  task automatic step();
    bit eb;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (!we_n && !ce_n && dq_oe) sram_mem[sram_addr] = dq_out;
    sram_dq_in = (!oe_n && !ce_n) ? sram_rd(sram_addr) : 16'hDEAD;
    if (busy && !busy_prev) dut_grants.push_back(!we_n);
    busy_prev = busy;
    eb = (win_left > 0);
    check_eq("ctrl", 64'({busy, we_n, oe_n, ce_n, lb_n, ub_n, dq_oe, wr_ack, rd_ack}),
             64'({eb, !(eb && win_wr), !(eb && !win_wr), in_rst, in_rst, in_rst,
                  eb && win_wr, ack_w, ack_r}));
    check_eq("addr", 64'(sram_addr), 64'(e_addr));
    check_eq("dq_out", 64'(dq_out), 64'(e_dq));
    check_eq("rd_data", 64'(rd_data), 64'(e_rd));
  endtask

  function automatic logic [19:0] pick_addr();
    case ($urandom_range(0, 4))
      0:       return 20'h00000;
      1:       return 20'hFFFFF;
      2:       return 20'h00010;
      3:       return 20'h00020;
      default: return 20'($urandom_range(0, 15));
    endcase
  endfunction

  logic [3:0] sim_tbl [6];
  int n;
  bit wp, rp;

  initial begin
    // Reset with both requests high.
    rst_n = 1'b0;
    wr_req = 1'b1;
    rd_req = 1'b1;
    repeat (3) begin
      step();
      check_eq("rst_ack", 64'({wr_ack, rd_ack}), 64'd0);
      check_eq("rst_ce_n", 64'(ce_n), 64'd1);
    end
    rst_n = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    step();
    check_eq("run_ce_n", 64'(ce_n), 64'd0);

    // Single write; requester address changes mid-window must be ignored.
    wr_req = 1'b1;
    wr_addr = 20'h00010;
    wr_data = 16'hBEEF;
    step();
    check_eq("wr_c1", 64'({we_n, dq_oe, sram_addr, dq_out}), 64'({1'b0, 1'b1, 20'h00010, 16'hBEEF}));
    wr_addr = 20'h33333;
    wr_data = 16'h0000;
    step();
    check_eq("wr_c2", 64'({we_n, dq_oe, sram_addr, dq_out}), 64'({1'b0, 1'b1, 20'h00010, 16'hBEEF}));
    step();
    check_eq("wr_ack", 64'({wr_ack, we_n, dq_oe}), 64'({1'b1, 1'b1, 1'b0}));
    wr_req = 1'b0;
    step();
    check_eq("wr_ack_drop", 64'(wr_ack), 64'd0);

    // Single read of a preloaded word; data held after the ack.
    sram_mem[20'h00020] = 16'h1234;
    ref_mem[20'h00020] = 16'h1234;
    rd_req = 1'b1;
    rd_addr = 20'h00020;
    step();
    check_eq("rd_c1", 64'({oe_n, dq_oe, sram_addr}), 64'({1'b0, 1'b0, 20'h00020}));
    step();
    check_eq("rd_c2", 64'({oe_n, dq_oe}), 64'd0);
    step();
    check_eq("rd_ack", 64'({rd_ack, rd_data}), 64'({1'b1, 16'h1234}));
    rd_req = 1'b0;
    step();
    check_eq("rd_hold", 64'({rd_ack, rd_data}), 64'({1'b0, 16'h1234}));

    // Simultaneous requests right after reset: write first, then read.
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    wr_req = 1'b1;
    rd_req = 1'b1;
    wr_addr = pick_addr();
    wr_data = 16'($urandom);
    rd_addr = pick_addr();
    sim_tbl = '{4'b0100, 4'b0100, 4'b1110, 4'b1000, 4'b1000, 4'b1101};
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq($sformatf("sim_c%0d", i + 1), 64'({we_n, oe_n, wr_ack, rd_ack}), 64'(sim_tbl[i]));
      if (wr_ack) wr_req = 1'b0;
      if (rd_ack) rd_req = 1'b0;
    end

    // Sustained contention must alternate W,R,W,R...
    dut_grants.delete();
    wr_req = 1'b1;
    rd_req = 1'b1;
    n = 0;
    while (dut_grants.size() < 8 && n < 80) begin
      step();
      n++;
      if (wr_ack) begin
        wr_addr = pick_addr();
        wr_data = 16'($urandom);
      end
      if (rd_ack) rd_addr = pick_addr();
    end
    check_eq("alt_count", 64'(dut_grants.size()), 64'd8);
    for (int i = 0; i < dut_grants.size(); i++)
      check_eq($sformatf("alt_order%0d", i), 64'(dut_grants[i]), 64'(i % 2 == 0));
    wr_req = 1'b0;
    n = 0;
    while (rd_req && n < 10) begin
      step();
      n++;
      if (rd_ack) rd_req = 1'b0;
    end
    check_eq("alt_drain", 64'(rd_req), 64'd0);
    rd_req = 1'b0;
    step();

    // Reset during the first cycle of a write window aborts it without an ack.
    wr_req = 1'b1;
    wr_addr = 20'h00044;
    wr_data = 16'h5A5A;
    step();
    check_eq("abort_c1", 64'(we_n), 64'd0);
    rst_n = 1'b0;
    step();
    check_eq("abort_rst", 64'({we_n, dq_oe, wr_ack}), 64'({1'b1, 1'b0, 1'b0}));
    rst_n = 1'b1;
    step();
    check_eq("reserve_c1", 64'({we_n, dq_oe, sram_addr}), 64'({1'b0, 1'b1, 20'h00044}));
    step();
    check_eq("reserve_c2", 64'({we_n, wr_ack}), 64'({1'b0, 1'b0}));
    step();
    check_eq("reserve_ack", 64'({we_n, wr_ack}), 64'({1'b1, 1'b1}));
    wr_req = 1'b0;
    step();

    // Random traffic obeying the hold-until-ack protocol.
    wp = 1'b0;
    rp = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!wp && $urandom_range(0, 2) == 0) begin
        wp = 1'b1;
        wr_req = 1'b1;
        wr_addr = pick_addr();
        wr_data = 16'($urandom);
      end
      if (!rp && $urandom_range(0, 2) == 0) begin
        rp = 1'b1;
        rd_req = 1'b1;
        rd_addr = pick_addr();
      end
      step();
      if (wr_ack) begin
        wp = 1'b0;
        wr_req = 1'b0;
      end
      if (rd_ack) begin
        rp = 1'b0;
        rd_req = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
